// File: rtl/pipelined_ctrl_hazard_unit.sv
// pipelined_ctrl_hazard_unit: decodes the D-stage instruction once, carries the control word
// through DX/XM/MW and detects load-use, branch-operand and MULT/DIV hazards.
`default_nettype none

module pipelined_ctrl_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int ALU_CW     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_stall,
    input  logic              fd_valid,
    input  logic [31:0]       fd_instr,
    input  logic              fd_rs_eq_rt,
    output logic              stall_fd,
    output logic              flush_fd,
    output logic [1:0]        d_pc_sel,
    output logic              d_is_shift,
    output logic [ALU_CW-1:0] x_alu_ctrl,
    output logic              x_alu_src,
    output logic              x_is_shift,
    output logic              x_md_start,
    output logic              x_md_is_div,
    output logic              md_busy,
    output logic              m_mem_read,
    output logic              m_mem_write,
    output logic              m_reg_write,
    output logic [REG_AW-1:0] m_dst,
    output logic              w_reg_write,
    output logic [REG_AW-1:0] w_dst,
    output logic              w_mem_to_reg,
    output logic              w_is_jal
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [ALU_CW-1:0] ALU_ADD = ALU_CW'(0);
    localparam logic [ALU_CW-1:0] ALU_AND = ALU_CW'(1);
    localparam logic [ALU_CW-1:0] ALU_OR  = ALU_CW'(2);
    localparam logic [ALU_CW-1:0] ALU_SLL = ALU_CW'(3);
    localparam logic [ALU_CW-1:0] ALU_SLT = ALU_CW'(4);
    localparam logic [ALU_CW-1:0] ALU_SRL = ALU_CW'(5);
    localparam logic [ALU_CW-1:0] ALU_SUB = ALU_CW'(6);
    localparam logic [ALU_CW-1:0] ALU_XOR = ALU_CW'(7);

    // dst is held at 0 for instructions that do not write a GPR, so dst!=0 is the write enable.
    typedef struct packed {
        logic              valid;
        logic [ALU_CW-1:0] alu_ctrl;
        logic              alu_src;
        logic              is_shift;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              is_jal;
        logic              is_md;
        logic              md_div;
        logic [REG_AW-1:0] dst;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] ins);
        ctrl_t c;
        logic [5:0] op;
        logic [5:0] fn;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        op = ins[31:26];
        fn = ins[5:0];
        rt = REG_AW'(ins[20:16]);
        rd = REG_AW'(ins[15:11]);
        c = '0;
        c.valid = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  begin c.alu_ctrl = ALU_ADD; c.dst = rd; end
                    FN_SUB:  begin c.alu_ctrl = ALU_SUB; c.dst = rd; end
                    FN_AND:  begin c.alu_ctrl = ALU_AND; c.dst = rd; end
                    FN_OR:   begin c.alu_ctrl = ALU_OR;  c.dst = rd; end
                    FN_XOR:  begin c.alu_ctrl = ALU_XOR; c.dst = rd; end
                    FN_SLT:  begin c.alu_ctrl = ALU_SLT; c.dst = rd; end
                    FN_SLL:  begin c.alu_ctrl = ALU_SLL; c.is_shift = 1'b1; c.dst = rd; end
                    FN_SRL:  begin c.alu_ctrl = ALU_SRL; c.is_shift = 1'b1; c.dst = rd; end
                    FN_MFHI: c.dst = rd;
                    FN_MFLO: c.dst = rd;
                    FN_MULT: c.is_md = 1'b1;
                    FN_DIV:  begin c.is_md = 1'b1; c.md_div = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin c.alu_ctrl = ALU_ADD; c.alu_src = 1'b1; c.dst = rt; end
            OP_ANDI: begin c.alu_ctrl = ALU_AND; c.alu_src = 1'b1; c.dst = rt; end
            OP_ORI:  begin c.alu_ctrl = ALU_OR;  c.alu_src = 1'b1; c.dst = rt; end
            OP_XORI: begin c.alu_ctrl = ALU_XOR; c.alu_src = 1'b1; c.dst = rt; end
            OP_SLTI: begin c.alu_ctrl = ALU_SLT; c.alu_src = 1'b1; c.dst = rt; end
            OP_LW, OP_LB: begin
                c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.dst = rt;
            end
            OP_SW, OP_SB: begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
            OP_BEQ, OP_BNE: c.alu_ctrl = ALU_SUB;
            OP_JAL: begin c.is_jal = 1'b1; c.dst = {REG_AW{1'b1}}; end
            default: ;
        endcase
        return c;
    endfunction

    ctrl_t dx, xm, mw;
    ctrl_t d_ctrl;
    logic [CNT_W-1:0] md_cnt;

    logic [5:0]        d_op, d_fn;
    logic [REG_AW-1:0] d_rs, d_rt;
    logic d_beq, d_bne, d_jr, d_jump, d_md_class, d_reads_rt, d_br_rt;
    logic ld_use, br_haz, md_haz, hazard;
    logic dx_match, xm_match;
    logic md_advance;
    logic unused_bits;

    assign d_op   = fd_instr[31:26];
    assign d_fn   = fd_instr[5:0];
    assign d_rs   = REG_AW'(fd_instr[25:21]);
    assign d_rt   = REG_AW'(fd_instr[20:16]);
    assign d_ctrl = decode(fd_instr);

    assign d_beq      = (d_op == OP_BEQ);
    assign d_bne      = (d_op == OP_BNE);
    assign d_jr       = (d_op == OP_RTYPE) && (d_fn == FN_JR);
    assign d_jump     = (d_op == OP_J) || (d_op == OP_JAL);
    assign d_md_class = (d_op == OP_RTYPE) &&
                        ((d_fn == FN_MULT) || (d_fn == FN_DIV) ||
                         (d_fn == FN_MFHI) || (d_fn == FN_MFLO));
    assign d_reads_rt = (d_op == OP_RTYPE) || d_beq || d_bne ||
                        (d_op == OP_SW) || (d_op == OP_SB);
    assign d_br_rt    = d_beq || d_bne;

    assign ld_use   = dx.mem_read && (dx.dst != '0) &&
                      ((dx.dst == d_rs) || (d_reads_rt && (dx.dst == d_rt)));
    assign dx_match = (dx.dst != '0) && ((dx.dst == d_rs) || (d_br_rt && (dx.dst == d_rt)));
    assign xm_match = (xm.dst != '0) && ((xm.dst == d_rs) || (d_br_rt && (xm.dst == d_rt)));
    assign br_haz   = (d_beq || d_bne || d_jr) && (dx_match || (xm.mem_read && xm_match));
    assign md_haz   = d_md_class && (md_busy || dx.is_md);
    assign hazard   = fd_valid && (ld_use || br_haz || md_haz);

    assign md_advance = dx.is_md && !ext_stall;
    assign md_busy    = (md_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx     <= '0;
            xm     <= '0;
            mw     <= '0;
            md_cnt <= '0;
        end else begin
            if (md_advance) begin
                md_cnt <= dx.md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - CNT_W'(1);
            end
            if (!ext_stall) begin
                mw <= xm;
                xm <= dx;
                dx <= (hazard || !fd_valid) ? '0 : d_ctrl;
            end
        end
    end

    // D-side outputs are forced low while reset is asserted, independent of fd_* inputs.
    always_comb begin
        stall_fd   = 1'b0;
        flush_fd   = 1'b0;
        d_pc_sel   = 2'd0;
        d_is_shift = 1'b0;
        if (rst_n) begin
            stall_fd   = ext_stall || hazard;
            d_is_shift = fd_valid && d_ctrl.is_shift;
            if (!stall_fd && fd_valid) begin
                if (d_jump) begin
                    d_pc_sel = 2'd1;
                end else if ((d_beq && fd_rs_eq_rt) || (d_bne && !fd_rs_eq_rt)) begin
                    d_pc_sel = 2'd2;
                end else if (d_jr) begin
                    d_pc_sel = 2'd3;
                end
            end
            flush_fd = (d_pc_sel != 2'd0);
        end
    end

    assign x_alu_ctrl   = dx.alu_ctrl;
    assign x_alu_src    = dx.alu_src;
    assign x_is_shift   = dx.is_shift;
    assign x_md_start   = md_advance;
    assign x_md_is_div  = dx.md_div;

    assign m_mem_read   = xm.mem_read;
    assign m_mem_write  = xm.mem_write;
    assign m_reg_write  = xm.valid && (xm.dst != '0);
    assign m_dst        = xm.dst;

    assign w_reg_write  = mw.valid && (mw.dst != '0) && !ext_stall;
    assign w_dst        = mw.dst;
    assign w_mem_to_reg = mw.mem_to_reg;
    assign w_is_jal     = mw.is_jal;

    assign unused_bits  = ^{fd_instr[10:6], mw};

endmodule

`default_nettype wire

// File: doc/pipelined_ctrl_hazard_unit.md
Name: pipelined_ctrl_hazard_unit

Overview:
- Parametrised successor to the per-stage combinational decoder of the 5-stage MIPS core.
- Decodes the instruction in D once into a control word and carries it through internal DX/XM/MW registers, with explicit valid bits. An explicit valid bit replaces the zero-rs/rt/rd stall heuristic.
- Adds hazard handling: load-use stall, branch-operand stall, branch/jump flush, and a multi-cycle MULT/DIV busy tracker with HI/LO interlock.
- Sits between the IF/ID register and the datapath muxes. The forwarding unit consumes its m_/w_ outputs.

Parameters:
REG_AW, 5, register address width
ALU_CW, 4, ALU control width (>=3)
MUL_CYCLES, 4, MULT occupancy in cycles (>=1)
DIV_CYCLES, 8, DIV occupancy in cycles (>=1, >=MUL_CYCLES)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ext_stall  in  1  memory stall; freezes all stage registers
fd_valid  in  1  IF/ID holds a real instruction
fd_instr  in  32  instruction in D
fd_rs_eq_rt  in  1  forwarded GPR[rs]==GPR[rt], computed in D
stall_fd  out  1  hold PC and IF/ID
flush_fd  out  1  load bubble into IF/ID next edge
d_pc_sel  out  2  0=PC+4, 1=jump target, 2=branch target, 3=GPR[rs]
d_is_shift  out  1  D reads rt on port 1 (SLL/SRL)
x_alu_ctrl  out  ALU_CW  ALU op; ADD=0 AND=1 OR=2 SLL=3 SLT=4 SRL=5 SUB=6 XOR=7
x_alu_src  out  1  1=immediate operand
x_is_shift  out  1  shamt operand
x_md_start  out  1  one-cycle pulse starting the MULT/DIV unit
x_md_is_div  out  1  qualifies x_md_start
md_busy  out  1  MULT/DIV in progress
m_mem_read  out  1  LW/LB in M
m_mem_write  out  1  SW/SB in M
m_reg_write  out  1  M-stage instruction will write a GPR
m_dst  out  REG_AW  its destination
w_reg_write  out  1  GPR write enable
w_dst  out  REG_AW  write address: rd (R-type), rt (I-type), 31 (JAL)
w_mem_to_reg  out  1  write data from memory
w_is_jal  out  1  write data is PC+8

Behaviour:
- Decode covers the existing opcode/funct set, plus MULT 011000, DIV 011010, MFHI 010000, MFLO 010010.
- Bubble = valid=0 with all control bits 0.
- Reset (async, rst_n=0): DX/XM/MW become bubbles; MD counter=0; every output is 0.
- Derived write enable: reg_write = valid and writes-GPR and dst!=0.
  - Writes-GPR excludes SW, SB, BEQ, BNE, J, JR, MULT, DIV.
- Stage advance each edge with ext_stall=0:
  - MW<=XM; XM<=DX.
  - DX<=bubble if a hazard is detected or fd_valid=0; otherwise DX<=decode(fd_instr).
- Hazards, combinational in D, valid instruction only; each raises stall_fd for 1 cycle:
  - Load-use: DX is LW/LB with dst!=0 and dst==rs, or dst==rt when D reads rt (R-type, BEQ/BNE, SW/SB).
  - Branch operand: D is BEQ/BNE/JR, and either
    - DX reg_write with dst matching a source, or
    - XM is a load with dst matching a source.
    The XM-load case stalls again the next cycle if needed (two cycles total after a load).
  - MD interlock: D is MFHI/MFLO/MULT/DIV and md_busy=1, or DX is MULT/DIV.
- stall_fd=1 forces d_pc_sel=0 and flush_fd=0. A branch resolves only once unstalled.
- Unstalled D:
  - J/JAL gives sel=1.
  - Taken BEQ (fd_rs_eq_rt=1) or BNE (=0) gives sel=2.
  - JR gives sel=3.
  - flush_fd=1 whenever sel!=0.
- MD counter:
  - Loads MUL_CYCLES (or DIV_CYCLES) when a valid MULT/DIV advances from DX to XM. x_md_start=1 during that cycle.
  - Otherwise decrements while nonzero.
  - md_busy = counter!=0.
  - The counter still decrements under ext_stall. x_md_start is gated by ext_stall=0.
- ext_stall=1:
  - DX/XM/MW hold.
  - stall_fd=1, flush_fd=0, d_pc_sel=0.
  - w_reg_write=0, so a held MW is not written twice.
- Priority: reset > ext_stall > hazard > flush.
- Outputs prefixed x_/m_/w_ are decoded from the DX/XM/MW registers.
  - When the stage is a bubble, all of those outputs are 0, except x_alu_ctrl=0.
  - d_/stall/flush outputs are combinational from D and the stage registers.

Test Plan:
- LW $2 then ADD $3,$2,$4 -> stall_fd=1 for exactly 1 cycle; the bubble appears in DX; ADD later shows x_alu_ctrl=0; w_dst=3 with w_reg_write=1.
- ADDI $5 then BEQ $5,$6 (fd_rs_eq_rt=1 once unstalled) -> 1 stall cycle, then d_pc_sel=2, flush_fd=1 for 1 cycle; BEQ never raises w_reg_write.
- MULT then MFLO directly behind it, MUL_CYCLES=4 -> x_md_start pulses once; md_busy high 4 cycles; MFLO held in D until md_busy=0.
- JAL -> d_pc_sel=1, flush_fd=1; three cycles later w_is_jal=1, w_dst=31, w_reg_write=1.
- ext_stall held 3 cycles with ADD in MW -> w_reg_write=0 during the stall; it rises exactly once after release; stage contents are unchanged.
- rst_n low mid-DIV (counter=5) -> md_busy=0 and all outputs 0 immediately (asynchronously); after release, the first instruction decodes normally.
